// File: rtl/gripper_pkg.sv
// Shared definitions for the soft-gripper actuation stage: pump channel
// state encoding and default timing constants also used by the PID block.
package gripper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEAL = 2'd1,
        ST_RUN  = 2'd2
    } pump_state_e;

    localparam int DEF_PERIOD     = 1000;
    localparam int DEF_SEAL_TICKS = 100;

endpackage

// File: rtl/pump_pwm_channel.sv
// One pump/valve channel: command clamp, slew limiter, seal/run/vent FSM
// and PWM comparator against the shared period counter.
module pump_pwm_channel
    import gripper_pkg::*;
#(
    parameter int IN_W       = 16,
    parameter int CNT_W      = 16,
    parameter int PERIOD     = DEF_PERIOD,
    parameter int MAX_SLEW   = 50,
    parameter int SEAL_TICKS = DEF_SEAL_TICKS
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             tick_en_i,
    input  logic             wrap_i,
    input  logic [CNT_W-1:0] cnt_d_i,
    input  logic             start_i,
    input  logic [IN_W-1:0]  duty_i,
    output logic             pump_o,
    output logic             valve_o,
    output logic [CNT_W-1:0] duty_o
);

    localparam int                      SEAL_W    = (SEAL_TICKS < 2) ? 1 : $clog2(SEAL_TICKS);
    localparam logic [SEAL_W-1:0]       SEAL_LAST = SEAL_W'((SEAL_TICKS > 0) ? SEAL_TICKS - 1 : 0);
    localparam logic signed [IN_W:0]    PERIOD_S  = (IN_W+1)'(PERIOD);
    localparam logic [CNT_W-1:0]        PERIOD_C  = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0]        SLEW_C    = CNT_W'(MAX_SLEW);

    pump_state_e       state_q, state_d;
    logic [SEAL_W-1:0] seal_q, seal_d;
    logic [CNT_W-1:0]  duty_q, duty_d;
    logic              pump_q, pump_d;
    logic              valve_q, valve_d;

    logic signed [IN_W:0] din_s;
    logic [CNT_W-1:0]     target;
    logic [CNT_W-1:0]     step;
    logic [CNT_W-1:0]     slewed;

    // Sign-extend by one bit so PERIOD compares safely against any command.
    assign din_s = {duty_i[IN_W-1], duty_i};

    always_comb begin
        target = CNT_W'(din_s);
        if (din_s[IN_W]) begin
            target = '0;
        end else if (din_s > PERIOD_S) begin
            target = PERIOD_C;
        end
    end

    always_comb begin
        slewed = target;
        step   = '0;
        if (MAX_SLEW != 0) begin
            if (target > duty_q) begin
                step   = target - duty_q;
                slewed = (step > SLEW_C) ? duty_q + SLEW_C : target;
            end else begin
                step   = duty_q - target;
                slewed = (step > SLEW_C) ? duty_q - SLEW_C : target;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        seal_d  = seal_q;
        duty_d  = duty_q;
        case (state_q)
            ST_IDLE: begin
                seal_d = '0;
                duty_d = '0;
                if (start_i) begin
                    state_d = ST_SEAL;
                end
            end
            ST_SEAL: begin
                if (!start_i) begin
                    state_d = ST_IDLE;
                    seal_d  = '0;
                end else if (tick_en_i) begin
                    if (seal_q == SEAL_LAST) begin
                        state_d = ST_RUN;
                        seal_d  = '0;
                    end else begin
                        seal_d = seal_q + SEAL_W'(1);
                    end
                end
            end
            ST_RUN: begin
                if (!start_i) begin
                    state_d = ST_IDLE;
                    duty_d  = '0;
                end else if (wrap_i) begin
                    duty_d = slewed;
                end
            end
            default: begin
                state_d = ST_IDLE;
                seal_d  = '0;
                duty_d  = '0;
            end
        endcase
    end

    // Outputs are computed from next-state values so the registered pins
    // line up with the registered counter and state on the same edge.
    assign pump_d  = (state_d == ST_RUN) && (cnt_d_i < duty_d);
    assign valve_d = (state_d == ST_IDLE);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            seal_q  <= '0;
            duty_q  <= '0;
            pump_q  <= 1'b0;
            valve_q <= 1'b1;
        end else begin
            state_q <= state_d;
            seal_q  <= seal_d;
            duty_q  <= duty_d;
            pump_q  <= pump_d;
            valve_q <= valve_d;
        end
    end

    assign pump_o  = pump_q;
    assign valve_o = valve_q;
    assign duty_o  = duty_q;

endmodule

// File: rtl/pump_pwm_array.sv
// N-channel pump/valve driver: shared PWM period counter and period_end
// strobe feeding one pump_pwm_channel per channel.
module pump_pwm_array
    import gripper_pkg::*;
#(
    parameter int N_CH       = 2,
    parameter int IN_W       = 16,
    parameter int CNT_W      = 16,
    parameter int PERIOD     = DEF_PERIOD,
    parameter int MAX_SLEW   = 50,
    parameter int SEAL_TICKS = DEF_SEAL_TICKS
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  tick_en,
    input  logic [N_CH-1:0]       start,
    input  logic [N_CH*IN_W-1:0]  duty_in,
    output logic [N_CH-1:0]       pump_out,
    output logic [N_CH-1:0]       valve_out,
    output logic [N_CH*CNT_W-1:0] duty_cur,
    output logic                  period_end
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             period_end_q;
    logic             wrap;

    always_comb begin
        wrap  = tick_en && (cnt_q == CNT_LAST);
        cnt_d = cnt_q;
        if (tick_en) begin
            cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_q        <= '0;
            period_end_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            period_end_q <= wrap;
        end
    end

    assign period_end = period_end_q;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            pump_pwm_channel #(
                .IN_W      (IN_W),
                .CNT_W     (CNT_W),
                .PERIOD    (PERIOD),
                .MAX_SLEW  (MAX_SLEW),
                .SEAL_TICKS(SEAL_TICKS)
            ) u_ch (
                .CLK      (CLK),
                .RESET    (RESET),
                .tick_en_i(tick_en),
                .wrap_i   (wrap),
                .cnt_d_i  (cnt_d),
                .start_i  (start[gi]),
                .duty_i   (duty_in[gi*IN_W +: IN_W]),
                .pump_o   (pump_out[gi]),
                .valve_o  (valve_out[gi]),
                .duty_o   (duty_cur[gi*CNT_W +: CNT_W])
            );
        end
    endgenerate

endmodule

// File: tb/tb_pump_pwm_array.sv
// Bench for pump_pwm_array: a 4-channel unslewed instance and a 2-channel
// slewed instance checked every cycle against a behavioural model.
module tb_pump_pwm_array;

    localparam int M_IDLE = 0;
    localparam int M_SEAL = 1;
    localparam int M_RUN  = 2;

    logic        CLK;
    logic        RESET;
    logic        tick_en;
    logic        tick_hold;
    logic [3:0]  start_a;
    logic [63:0] duty_in_a;
    logic [3:0]  pump_a, valve_a;
    logic [63:0] duty_a;
    logic        pe_a;
    logic [1:0]  start_b;
    logic [31:0] duty_in_b;
    logic [1:0]  pump_b, valve_b;
    logic [31:0] duty_b;
    logic        pe_b;

    int n_vec = 0;
    int n_miss = 0;

    pump_pwm_array #(.N_CH(4), .IN_W(16), .CNT_W(16), .PERIOD(1000),
                     .MAX_SLEW(0), .SEAL_TICKS(100)) dut_a (
        .CLK(CLK), .RESET(RESET), .tick_en(tick_en), .start(start_a),
        .duty_in(duty_in_a), .pump_out(pump_a), .valve_out(valve_a),
        .duty_cur(duty_a), .period_end(pe_a)
    );

    pump_pwm_array #(.N_CH(2), .IN_W(16), .CNT_W(16), .PERIOD(1000),
                     .MAX_SLEW(50), .SEAL_TICKS(100)) dut_b (
        .CLK(CLK), .RESET(RESET), .tick_en(tick_en), .start(start_b),
        .duty_in(duty_in_b), .pump_out(pump_b), .valve_out(valve_b),
        .duty_cur(duty_b), .period_end(pe_b)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        tick_en = 1'b1;
        forever begin
            @(posedge CLK);
            #1;
            tick_en = !tick_hold;
        end
    end

    // ---------------- behavioural model ----------------
    int m_cnt [2];
    int m_st  [2][4];
    int m_seal[2][4];
    int m_duty[2][4];
    bit m_pump[2][4];
    bit m_valve[2][4];
    bit m_pe  [2];
    bit m_valid = 1'b0;
    int tick_total = 0;

    task automatic model_step(input int i);
        int  nch, slew, ncnt, tgt, d, dv;
        bit  wrap, st_b;
        nch  = (i == 0) ? 4 : 2;
        slew = (i == 0) ? 0 : 50;
        if (RESET) begin
            m_cnt[i] = 0;
            m_pe[i]  = 1'b0;
            for (int ch = 0; ch < 4; ch++) begin
                m_st[i][ch]    = M_IDLE;
                m_seal[i][ch]  = 0;
                m_duty[i][ch]  = 0;
                m_pump[i][ch]  = 1'b0;
                m_valve[i][ch] = 1'b1;
            end
        end else begin
            wrap = tick_en && (m_cnt[i] == 999);
            ncnt = tick_en ? (wrap ? 0 : m_cnt[i] + 1) : m_cnt[i];
            for (int ch = 0; ch < nch; ch++) begin
                st_b = (i == 0) ? start_a[ch] : start_b[ch];
                dv   = (i == 0) ? int'($signed(duty_in_a[ch*16 +: 16]))
                                : int'($signed(duty_in_b[ch*16 +: 16]));
                if (!st_b) begin
                    m_st[i][ch]   = M_IDLE;
                    m_duty[i][ch] = 0;
                    m_seal[i][ch] = 0;
                end else if (m_st[i][ch] == M_IDLE) begin
                    m_st[i][ch]   = M_SEAL;
                    m_seal[i][ch] = 0;
                end else if (m_st[i][ch] == M_SEAL) begin
                    if (tick_en) m_seal[i][ch]++;
                    if (m_seal[i][ch] == 100) m_st[i][ch] = M_RUN;
                end else if (wrap) begin
                    tgt = (dv < 0) ? 0 : ((dv > 1000) ? 1000 : dv);
                    d   = tgt - m_duty[i][ch];
                    if (slew != 0 && d > slew)  d = slew;
                    if (slew != 0 && d < -slew) d = -slew;
                    m_duty[i][ch] += d;
                end
                m_pump[i][ch]  = (m_st[i][ch] == M_RUN) && (ncnt < m_duty[i][ch]);
                m_valve[i][ch] = (m_st[i][ch] == M_IDLE);
            end
            m_cnt[i] = ncnt;
            m_pe[i]  = wrap;
        end
    endtask

    initial begin
        forever begin
            @(posedge CLK);
            model_step(0);
            model_step(1);
            if (RESET) m_valid = 1'b1;
            if (tick_en) tick_total++;
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [3:0]  ep_a, ev_a;
    logic [63:0] ed_a;
    logic [1:0]  ep_b, ev_b;
    logic [31:0] ed_b;

    initial begin
        forever begin
            @(negedge CLK);
            if (m_valid) begin
                for (int k = 0; k < 4; k++) begin
                    ep_a[k] = m_pump[0][k];
                    ev_a[k] = m_valve[0][k];
                    ed_a[k*16 +: 16] = 16'(m_duty[0][k]);
                end
                for (int k = 0; k < 2; k++) begin
                    ep_b[k] = m_pump[1][k];
                    ev_b[k] = m_valve[1][k];
                    ed_b[k*16 +: 16] = 16'(m_duty[1][k]);
                end
                n_vec++;
                if (pump_a !== ep_a || valve_a !== ev_a || duty_a !== ed_a || pe_a !== m_pe[0]) begin
                    n_miss++;
                    $display("FAIL cycle_a t=%0t: got pump=%b valve=%b duty=%h pe=%b, want pump=%b valve=%b duty=%h pe=%b",
                             $time, pump_a, valve_a, duty_a, pe_a, ep_a, ev_a, ed_a, m_pe[0]);
                end
                n_vec++;
                if (pump_b !== ep_b || valve_b !== ev_b || duty_b !== ed_b || pe_b !== m_pe[1]) begin
                    n_miss++;
                    $display("FAIL cycle_b t=%0t: got pump=%b valve=%b duty=%h pe=%b, want pump=%b valve=%b duty=%h pe=%b",
                             $time, pump_b, valve_b, duty_b, pe_b, ep_b, ev_b, ed_b, m_pe[1]);
                end
            end
        end
    end

    // ---------------- period high-count and slew recorders ----------------
    int hc[4];
    int last_high[4];
    int slew_q[$];
    bit rec_en = 1'b0;

    initial begin
        for (int k = 0; k < 4; k++) begin
            hc[k] = 0;
            last_high[k] = -1;
        end
        forever begin
            @(negedge CLK);
            for (int k = 0; k < 4; k++) begin
                if (pe_a) begin
                    last_high[k] = hc[k];
                    hc[k] = int'(pump_a[k]);
                end else begin
                    hc[k] += int'(pump_a[k]);
                end
            end
            if (!RESET && rec_en && pe_b && start_b[0]) slew_q.push_back(int'(duty_b[15:0]));
        end
    end

    // ---------------- helpers ----------------
    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end else begin
            $display("check %s: %0d", name, act);
        end
    endtask

    task automatic check_min(input string name, input int act, input int lo);
        n_vec++;
        if (act < lo) begin
            n_miss++;
            $display("FAIL %s: got %0d, want at least %0d", name, act, lo);
        end else begin
            $display("check %s: %0d (>= %0d)", name, act, lo);
        end
    endtask

    task automatic set_da(input int k, input int v);
        duty_in_a[k*16 +: 16] = 16'(v);
    endtask

    task automatic set_db(input int k, input int v);
        duty_in_b[k*16 +: 16] = 16'(v);
    endtask

    task automatic wait_pe_a(input string name);
        int n;
        n = 0;
        step(1);
        while (!pe_a && n < 2500) begin
            step(1);
            n++;
        end
        check(name, 64'(pe_a), 64'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int t0, n;
        RESET     = 1'b1;
        tick_hold = 1'b0;
        start_a   = 4'hF;
        start_b   = 2'b11;
        duty_in_a = '0;
        duty_in_b = '0;
        set_da(0, -200);
        set_da(1, 1500);
        set_da(2, 400);
        set_da(3, 750);
        set_db(0, 400);
        set_db(1, 120);

        step(3);
        check("reset_pump_a", 64'(pump_a), 64'd0);
        check("reset_valve_a", 64'(valve_a), 64'hF);
        check("reset_duty_a", duty_a, 64'd0);
        check("reset_valve_b", 64'(valve_b), 64'h3);
        check("reset_period_end", 64'(pe_a), 64'd0);

        RESET   = 1'b0;
        start_a = 4'h0;
        start_b = 2'b00;
        step(1);

        start_b = 2'b11;
        rec_en  = 1'b1;
        start_a[1] = 1'b1;
        t0 = tick_total;
        step(1);
        check("valve_seal_a1", 64'(valve_a[1]), 64'd0);
        check("valve_seal_b", 64'(valve_b), 64'd0);
        n = 0;
        while (!pump_a[1] && n < 3000) begin
            step(1);
            n++;
        end
        check("pump_started_a1", 64'(pump_a[1]), 64'd1);
        check_min("seal_ticks_a1", tick_total - t0, 100);

        step(37); start_a[0] = 1'b1;
        step(37); start_a[2] = 1'b1;
        step(37); start_a[3] = 1'b1;
        step(2500);
        check("high_neg200", 64'(last_high[0]), 64'd0);
        check("high_1500", 64'(last_high[1]), 64'd1000);
        check("high_400", 64'(last_high[2]), 64'd400);
        check("high_750", 64'(last_high[3]), 64'd750);

        set_da(3, 250);
        wait_pe_a("pe_wait_1");
        step(1);
        check("midperiod_hold_750", 64'(last_high[3]), 64'd750);
        wait_pe_a("pe_wait_2");
        step(1);
        check("high_250", 64'(last_high[3]), 64'd250);
        check("high_400_again", 64'(last_high[2]), 64'd400);

        tick_hold = 1'b1;
        step(25);
        tick_hold = 1'b0;

        n = 0;
        while (!pump_a[2] && n < 2500) begin
            step(1);
            n++;
        end
        step(3);
        check("a2_high_before_abort", 64'(pump_a[2]), 64'd1);
        start_a[2] = 1'b0;
        step(1);
        check("abort_pump_a2", 64'(pump_a[2]), 64'd0);
        check("abort_valve_a2", 64'(valve_a[2]), 64'd1);
        check("abort_duty_a2", 64'(duty_a[47:32]), 64'd0);
        start_a[2] = 1'b1;
        t0 = tick_total;
        n = 0;
        while (!pump_a[2] && n < 3000) begin
            step(1);
            n++;
        end
        check("pump_restarted_a2", 64'(pump_a[2]), 64'd1);
        check_min("reseal_ticks_a2", tick_total - t0, 100);

        n = 0;
        while (slew_q.size() < 9 && n < 12000) begin
            step(1);
            n++;
        end
        rec_en = 1'b0;
        check("slew_samples", 64'(slew_q.size() >= 9), 64'd1);
        for (int k = 0; k < 9 && k < slew_q.size(); k++) begin
            check($sformatf("slew_step_%0d", k), 64'(slew_q[k]),
                  64'((50 * (k + 1) > 400) ? 400 : 50 * (k + 1)));
        end
        check("slew_partial_b1", 64'(duty_b[31:16]), 64'd120);

        set_db(0, 0);
        n = 0;
        step(1);
        while (!pe_b && n < 2500) begin
            step(1);
            n++;
        end
        check("slew_down_b0", 64'(duty_b[15:0]), 64'd350);
        check("slew_hold_b1", 64'(duty_b[31:16]), 64'd120);

        RESET = 1'b1;
        step(1);
        check("midreset_pump_a", 64'(pump_a), 64'd0);
        check("midreset_valve_a", 64'(valve_a), 64'hF);
        check("midreset_duty_a", duty_a, 64'd0);
        check("midreset_valve_b", 64'(valve_b), 64'h3);
        RESET   = 1'b0;
        start_a = 4'h0;
        start_b = 2'b00;
        step(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
